// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the configurable UART blocks
// (uart_rx_cfg today, uart_tx_cfg later).
//   parity_mode_e : runtime parity selection (2'b11 behaves as none)
//   rx_state_e    : receiver FSM states
//   OVERSAMPLE    : ticks per bit
//   SAMPLE_MID    : centre tick; votes are taken at MID-1, MID, MID+1
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int SAMPLE_MID = 8;

    typedef enum logic [1:0] {
        PAR_NONE     = 2'b00,
        PAR_EVEN     = 2'b01,
        PAR_ODD      = 2'b10,
        PAR_NONE_ALT = 2'b11
    } parity_mode_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2,
        BRK_WAIT
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: free-running oversample tick generator.
//   clk, rst_n : clock, synchronous active-low reset
//   restart    : force the count back to 0 (aligns ticks to a start edge)
//   div        : clk cycles per tick; 0 behaves as 1
//   tick       : 1-clk pulse on the terminal count
module uart_baud_tick #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             restart,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] term;

    always_comb begin
        term  = (div == '0) ? '0 : div - DIV_W'(1);
        // >= keeps the counter from running the long way round if div shrinks
        tick  = (cnt_q >= term) && !restart;
        cnt_d = (restart || tick) ? '0 : cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: configurable UART receiver, 16x oversampling, 3-tap majority vote.
//   rx_uart                        : async serial line, idle high
//   baud_div/parity_mode/two_stop  : frame config, latched at the start edge
//   rx_ready                       : consumer handshake
//   rx_data/rx_valid               : received word, held until accepted
//   parity_err/frame_err           : status of the held word
//   break_det/overrun              : 1-clk event pulses
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_uart,
    input  logic [DIV_W-1:0]  baud_div,
    input  parity_mode_e      parity_mode,
    input  logic              two_stop,
    input  logic              rx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              break_det,
    output logic              overrun
);

    logic              sync1_q, sync2_q;
    rx_state_e         state_q, state_d;
    logic [3:0]        s_q, s_d, bit_q, bit_d;
    logic              v0_q, v0_d, v1_q, v1_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              ones_q, ones_d, frm_q, frm_d, perr_q, perr_d;
    logic [DIV_W-1:0]  cfg_div_q, cfg_div_d;
    parity_mode_e      cfg_par_q, cfg_par_d;
    logic              cfg_two_q, cfg_two_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              valid_q, valid_d, perr_o_q, perr_o_d, ferr_o_q, ferr_o_d;
    logic              brk_q, brk_d, ovr_q, ovr_d;
    logic              tick, restart, decide, maj, fin, accept;

    uart_baud_tick #(.DIV_W(DIV_W)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .div     (cfg_div_q),
        .tick    (tick)
    );

    always_comb begin
        state_d   = state_q;
        s_d       = s_q;
        bit_d     = bit_q;
        v0_d      = v0_q;
        v1_d      = v1_q;
        shift_d   = shift_q;
        ones_d    = ones_q;
        frm_d     = frm_q;
        perr_d    = perr_q;
        cfg_div_d = cfg_div_q;
        cfg_par_d = cfg_par_q;
        cfg_two_d = cfg_two_q;
        rx_data_d = rx_data_q;
        valid_d   = valid_q;
        perr_o_d  = perr_o_q;
        ferr_o_d  = ferr_o_q;
        brk_d     = 1'b0;
        ovr_d     = 1'b0;
        restart   = 1'b0;
        fin       = 1'b0;
        accept    = valid_q && rx_ready;
        maj       = maj3(v0_q, v1_q, sync2_q);
        decide    = tick && (s_q == 4'(SAMPLE_MID + 1));

        // Sample counter and the first two votes run in every in-frame state
        if (state_q != IDLE && state_q != BRK_WAIT && tick) begin
            s_d = (s_q == 4'(OVERSAMPLE - 1)) ? '0 : s_q + 4'd1;
            if (s_q == 4'(SAMPLE_MID - 1)) v0_d = sync2_q;
            if (s_q == 4'(SAMPLE_MID))     v1_d = sync2_q;
        end

        case (state_q)
            IDLE: if (!sync2_q) begin
                state_d   = START;
                restart   = 1'b1;
                s_d       = '0;
                bit_d     = '0;
                ones_d    = 1'b0;
                frm_d     = 1'b0;
                perr_d    = 1'b0;
                cfg_div_d = baud_div;
                cfg_par_d = parity_mode;
                cfg_two_d = two_stop;
            end
            START: if (decide) state_d = maj ? IDLE : DATA;
            DATA: if (decide) begin
                shift_d = {maj, shift_q[DATA_W-1:1]};
                ones_d  = ones_q | maj;
                if (bit_q == 4'(DATA_W - 1))
                    state_d = (cfg_par_q == PAR_EVEN || cfg_par_q == PAR_ODD) ? PARITY : STOP1;
                else
                    bit_d = bit_q + 4'd1;
            end
            PARITY: if (decide) begin
                ones_d  = ones_q | maj;
                // even: error when data^bit is odd; odd mode inverts that
                perr_d  = (^shift_q) ^ maj ^ (cfg_par_q == PAR_ODD);
                state_d = STOP1;
            end
            STOP1: if (decide) begin
                if (cfg_two_q) begin
                    ones_d  = ones_q | maj;
                    frm_d   = frm_q | !maj;
                    state_d = STOP2;
                end else begin
                    fin = 1'b1;
                end
            end
            STOP2:    if (decide) fin = 1'b1;
            BRK_WAIT: if (sync2_q) state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (accept) valid_d = 1'b0;

        if (fin) begin
            if (!(ones_q | maj)) begin
                // every sampled bit of the frame was 0: a line break, not a word
                brk_d   = 1'b1;
                state_d = BRK_WAIT;
            end else begin
                // back to IDLE mid-stop-bit so a following start edge is not missed
                state_d = IDLE;
                if (!valid_q || accept) begin
                    rx_data_d = shift_q;
                    perr_o_d  = perr_q;
                    ferr_o_d  = frm_q | !maj;
                    valid_d   = 1'b1;
                end else begin
                    ovr_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            state_q   <= IDLE;
            s_q       <= '0;
            bit_q     <= '0;
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            shift_q   <= '0;
            ones_q    <= 1'b0;
            frm_q     <= 1'b0;
            perr_q    <= 1'b0;
            cfg_div_q <= '0;
            cfg_par_q <= PAR_NONE;
            cfg_two_q <= 1'b0;
            rx_data_q <= '0;
            valid_q   <= 1'b0;
            perr_o_q  <= 1'b0;
            ferr_o_q  <= 1'b0;
            brk_q     <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync1_q   <= rx_uart;
            sync2_q   <= sync1_q;
            state_q   <= state_d;
            s_q       <= s_d;
            bit_q     <= bit_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            shift_q   <= shift_d;
            ones_q    <= ones_d;
            frm_q     <= frm_d;
            perr_q    <= perr_d;
            cfg_div_q <= cfg_div_d;
            cfg_par_q <= cfg_par_d;
            cfg_two_q <= cfg_two_d;
            rx_data_q <= rx_data_d;
            valid_q   <= valid_d;
            perr_o_q  <= perr_o_d;
            ferr_o_q  <= ferr_o_d;
            brk_q     <= brk_d;
            ovr_q     <= ovr_d;
        end
    end

    assign rx_data    = rx_data_q;
    assign rx_valid   = valid_q;
    assign parity_err = perr_o_q;
    assign frame_err  = ferr_o_q;
    assign break_det  = brk_q;
    assign overrun    = ovr_q;

endmodule
